// File: rtl/stage_2_id_pkg.sv
// Shared definitions for the decode stage: bus widths, opcodes, ALU op indices,
// immediate selectors and the decode-to-execute bundle layout.
package stage_2_id_pkg;

   localparam int unsigned BUS_1_2  = 64;
   localparam int unsigned BUS_2_3  = 150;
   localparam int unsigned ALU_OP_W = 12;

   // One-hot ALU operation bit positions
   localparam int unsigned AluAdd  = 0;
   localparam int unsigned AluSub  = 1;
   localparam int unsigned AluSlt  = 2;
   localparam int unsigned AluSltu = 3;
   localparam int unsigned AluAnd  = 4;
   localparam int unsigned AluNor  = 5;
   localparam int unsigned AluOr   = 6;
   localparam int unsigned AluXor  = 7;
   localparam int unsigned AluSll  = 8;
   localparam int unsigned AluSrl  = 9;
   localparam int unsigned AluSra  = 10;
   localparam int unsigned AluLui  = 11;

   // inst[31:15] opcodes (3R and shift-immediate)
   localparam logic [16:0] Op17AddW  = 17'h00020;
   localparam logic [16:0] Op17SubW  = 17'h00022;
   localparam logic [16:0] Op17Slt   = 17'h00024;
   localparam logic [16:0] Op17Sltu  = 17'h00025;
   localparam logic [16:0] Op17Nor   = 17'h00028;
   localparam logic [16:0] Op17And   = 17'h00029;
   localparam logic [16:0] Op17Or    = 17'h0002a;
   localparam logic [16:0] Op17Xor   = 17'h0002b;
   localparam logic [16:0] Op17SlliW = 17'h00081;
   localparam logic [16:0] Op17SrliW = 17'h00089;
   localparam logic [16:0] Op17SraiW = 17'h00091;

   // inst[31:22] opcodes (2RI12)
   localparam logic [9:0] Op10AddiW = 10'h00a;
   localparam logic [9:0] Op10LdW   = 10'h0a2;
   localparam logic [9:0] Op10StW   = 10'h0a6;

   // inst[31:25] opcode (1RI20)
   localparam logic [6:0] Op7Lu12iW = 7'h0a;

   // inst[31:26] opcodes (branches)
   localparam logic [5:0] Op6Jirl = 6'h13;
   localparam logic [5:0] Op6B    = 6'h14;
   localparam logic [5:0] Op6Bl   = 6'h15;
   localparam logic [5:0] Op6Beq  = 6'h16;
   localparam logic [5:0] Op6Bne  = 6'h17;

   typedef enum logic [2:0] {
      ImmNone,
      ImmSi12,
      ImmUi5,
      ImmSi20,
      ImmOffs16,
      ImmOffs26
   } imm_sel_e;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic [31:0]         src1;
      logic [31:0]         src2;
      logic [31:0]         rkd_value;
      logic [4:0]          dest;
      logic                gr_we;
      logic                mem_we;
      logic                res_from_mem;
      logic [31:0]         pc;
      logic [1:0]          pad;
   } id_bundle_t;

   // Build the 32-bit immediate for the given format from the raw instruction
   function automatic logic [31:0] expand_imm(input imm_sel_e sel, input logic [31:0] inst);
      logic [31:0] imm;
      logic [25:0] offs26;
      offs26 = {inst[9:0], inst[25:10]};
      unique case (sel)
         ImmSi12:   imm = {{20{inst[21]}}, inst[21:10]};
         ImmUi5:    imm = {27'd0, inst[14:10]};
         ImmSi20:   imm = {inst[24:5], 12'd0};
         ImmOffs16: imm = {{14{inst[25]}}, inst[25:10], 2'b00};
         ImmOffs26: imm = {{4{offs26[25]}}, offs26, 2'b00};
         default:   imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/stage_2_id_regfile.sv
// 32x32 general register file: two combinational read ports, one write port.
// r0 is hardwired to zero; a same-cycle read of the written address sees the old value.
module stage_2_id_regfile (
   input  logic        clk_i,
   input  logic [4:0]  raddr1_i,
   output logic [31:0] rdata1_o,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata2_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   // Next-state of the array: single write, r0 never written
   always_comb begin
      rf_d = rf_q;
      if (we_i && (waddr_i != 5'd0)) begin
         rf_d[waddr_i] = wdata_i;
      end
   end

   // Storage update
   always_ff @(posedge clk_i) begin
      rf_q <= rf_d;
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : rf_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : rf_q[raddr2_i];

endmodule

// File: rtl/stage_2_id.sv
// Decode stage of the five-stage LA32 pipeline. Latches {inst,pc} from fetch,
// decodes the supported subset, reads the register file, stalls on RAW hazards
// (no forwarding), resolves branches back to fetch and hands a bundle to execute.
module stage_2_id
   import stage_2_id_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1bff_fffc
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               valid_1,
   output logic               allow_2,
   input  logic [BUS_1_2-1:0] stage_1_to_2,
   output logic               br_taken,
   output logic [31:0]        br_target,
   output logic               valid_2,
   input  logic               allow_3,
   output logic [BUS_2_3-1:0] stage_2_to_3,
   input  logic               exe_we,
   input  logic [4:0]         exe_dest,
   input  logic               mem_we,
   input  logic [4:0]         mem_dest,
   input  logic               wb_hz_we,
   input  logic [4:0]         wb_hz_dest,
   input  logic               rf_we,
   input  logic [4:0]         rf_waddr,
   input  logic [31:0]        rf_wdata
);

   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q, pc_d;

   // Instruction fields
   logic [4:0] rd, rj, rk;
   assign rd = inst_q[4:0];
   assign rj = inst_q[9:5];
   assign rk = inst_q[14:10];

   // Opcode matches
   logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
   logic inst_slli_w, inst_srli_w, inst_srai_w, inst_addi_w, inst_ld_w, inst_st_w;
   logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_lu12i_w;
   logic inst_3r, inst_shift_i, inst_known, inst_link;

   assign inst_add_w   = inst_q[31:15] == Op17AddW;
   assign inst_sub_w   = inst_q[31:15] == Op17SubW;
   assign inst_slt     = inst_q[31:15] == Op17Slt;
   assign inst_sltu    = inst_q[31:15] == Op17Sltu;
   assign inst_nor     = inst_q[31:15] == Op17Nor;
   assign inst_and     = inst_q[31:15] == Op17And;
   assign inst_or      = inst_q[31:15] == Op17Or;
   assign inst_xor     = inst_q[31:15] == Op17Xor;
   assign inst_slli_w  = inst_q[31:15] == Op17SlliW;
   assign inst_srli_w  = inst_q[31:15] == Op17SrliW;
   assign inst_srai_w  = inst_q[31:15] == Op17SraiW;
   assign inst_addi_w  = inst_q[31:22] == Op10AddiW;
   assign inst_ld_w    = inst_q[31:22] == Op10LdW;
   assign inst_st_w    = inst_q[31:22] == Op10StW;
   assign inst_lu12i_w = inst_q[31:25] == Op7Lu12iW;
   assign inst_jirl    = inst_q[31:26] == Op6Jirl;
   assign inst_b       = inst_q[31:26] == Op6B;
   assign inst_bl      = inst_q[31:26] == Op6Bl;
   assign inst_beq     = inst_q[31:26] == Op6Beq;
   assign inst_bne     = inst_q[31:26] == Op6Bne;

   assign inst_3r      = inst_add_w | inst_sub_w | inst_slt | inst_sltu |
                         inst_nor | inst_and | inst_or | inst_xor;
   assign inst_shift_i = inst_slli_w | inst_srli_w | inst_srai_w;
   assign inst_link    = inst_jirl | inst_bl;
   assign inst_known   = inst_3r | inst_shift_i | inst_addi_w | inst_ld_w | inst_st_w |
                         inst_lu12i_w | inst_jirl | inst_b | inst_bl | inst_beq | inst_bne;

   // ALU operation (one-hot); address and link computations use add
   logic [ALU_OP_W-1:0] alu_op;
   assign alu_op[AluAdd]  = inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_link;
   assign alu_op[AluSub]  = inst_sub_w;
   assign alu_op[AluSlt]  = inst_slt;
   assign alu_op[AluSltu] = inst_sltu;
   assign alu_op[AluAnd]  = inst_and;
   assign alu_op[AluNor]  = inst_nor;
   assign alu_op[AluOr]   = inst_or;
   assign alu_op[AluXor]  = inst_xor;
   assign alu_op[AluSll]  = inst_slli_w;
   assign alu_op[AluSrl]  = inst_srli_w;
   assign alu_op[AluSra]  = inst_srai_w;
   assign alu_op[AluLui]  = inst_lu12i_w;

   // Immediate format selection
   imm_sel_e    imm_sel;
   logic [31:0] imm;
   always_comb begin
      imm_sel = ImmNone;
      if (inst_addi_w || inst_ld_w || inst_st_w) begin
         imm_sel = ImmSi12;
      end else if (inst_shift_i) begin
         imm_sel = ImmUi5;
      end else if (inst_lu12i_w) begin
         imm_sel = ImmSi20;
      end else if (inst_jirl || inst_beq || inst_bne) begin
         imm_sel = ImmOffs16;
      end else if (inst_b || inst_bl) begin
         imm_sel = ImmOffs26;
      end
   end
   assign imm = expand_imm(imm_sel, inst_q);

   // Register reads: second port takes rd for compare-branches and stores
   logic        src_is_rd;
   logic [4:0]  raddr2;
   logic [31:0] rj_value, rkd_value;
   logic        reads_rj, reads_r2;

   assign src_is_rd = inst_beq | inst_bne | inst_st_w;
   assign raddr2    = src_is_rd ? rd : rk;
   assign reads_rj  = inst_known & ~(inst_b | inst_bl | inst_lu12i_w);
   assign reads_r2  = inst_3r | src_is_rd;

   stage_2_id_regfile u_regfile (
      .clk_i    (clk),
      .raddr1_i (rj),
      .rdata1_o (rj_value),
      .raddr2_i (raddr2),
      .rdata2_o (rkd_value),
      .we_i     (rf_we),
      .waddr_i  (rf_waddr),
      .wdata_i  (rf_wdata)
   );

   // RAW hazard detection against every in-flight writer; r0 never hazards
   logic hit_rj, hit_r2, stall, ready_go;
   assign hit_rj = (exe_we && (exe_dest == rj)) || (mem_we && (mem_dest == rj)) ||
                   (wb_hz_we && (wb_hz_dest == rj));
   assign hit_r2 = (exe_we && (exe_dest == raddr2)) || (mem_we && (mem_dest == raddr2)) ||
                   (wb_hz_we && (wb_hz_dest == raddr2));
   assign stall  = valid_q & ((reads_rj & (rj != 5'd0) & hit_rj) |
                              (reads_r2 & (raddr2 != 5'd0) & hit_r2));
   assign ready_go = ~stall;

   // Branch resolution; stalled branches are suppressed through ready_go
   logic taken;
   assign taken = (inst_beq & (rj_value == rkd_value)) | (inst_bne & (rj_value != rkd_value)) |
                  inst_jirl | inst_b | inst_bl;
   assign br_taken  = valid_q & ready_go & taken;
   assign br_target = inst_jirl ? (rj_value + imm) : (pc_q + imm);

   // Handshake
   assign allow_2 = ~valid_q | (ready_go & allow_3);
   assign valid_2 = valid_q & ready_go;

   // Decoded bundle to execute; link instructions compute pc+4 in the ALU
   id_bundle_t bundle;
   always_comb begin
      bundle              = '0;
      bundle.alu_op       = alu_op;
      bundle.src1         = inst_link ? pc_q : rj_value;
      bundle.src2         = inst_3r ? rkd_value : (inst_link ? 32'd4 : imm);
      bundle.rkd_value    = rkd_value;
      bundle.dest         = inst_bl ? 5'd1 : rd;
      bundle.gr_we        = inst_known & ~(inst_st_w | inst_beq | inst_bne | inst_b);
      bundle.mem_we       = inst_st_w;
      bundle.res_from_mem = inst_ld_w;
      bundle.pc           = pc_q;
      bundle.pad          = 2'b00;
   end
   assign stage_2_to_3 = bundle;

   // Holding register next-state; a taken branch drops the fall-through fetch
   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      if (allow_2) begin
         valid_d = valid_1 & ~br_taken;
         inst_d  = stage_1_to_2[63:32];
         pc_d    = stage_1_to_2[31:0];
      end
   end

   // Holding registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         inst_q  <= 32'd0;
         pc_q    <= RESET_PC;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_stage_2_id.sv
// Directed bench for the decode stage: a table of single-instruction decode
// vectors plus hand-written sequences for hazards, branches, back-pressure and reset.
module tb_stage_2_id;

   logic         clk;
   logic         resetn;
   logic         valid_1;
   logic         allow_2;
   logic [63:0]  stage_1_to_2;
   logic         br_taken;
   logic [31:0]  br_target;
   logic         valid_2;
   logic         allow_3;
   logic [149:0] stage_2_to_3;
   logic         exe_we, mem_we, wb_hz_we;
   logic [4:0]   exe_dest, mem_dest, wb_hz_dest;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;

   int total = 0;
   int bad   = 0;

   stage_2_id #(.RESET_PC(32'h1bff_fffc)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .valid_1      (valid_1),
      .allow_2      (allow_2),
      .stage_1_to_2 (stage_1_to_2),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .valid_2      (valid_2),
      .allow_3      (allow_3),
      .stage_2_to_3 (stage_2_to_3),
      .exe_we       (exe_we),
      .exe_dest     (exe_dest),
      .mem_we       (mem_we),
      .mem_dest     (mem_dest),
      .wb_hz_we     (wb_hz_we),
      .wb_hz_dest   (wb_hz_dest),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_bus(input string name, input logic [149:0] act,
                            input logic [149:0] exp, input logic [149:0] mask);
      total++;
      if ((act & mask) !== (exp & mask)) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act & mask, exp & mask);
      end
   endtask

   function automatic logic [149:0] mk_bundle(
      input logic [11:0] alu, input logic [31:0] s1, input logic [31:0] s2,
      input logic [31:0] rkd, input logic [4:0] dest, input logic gw, input logic mw,
      input logic rfm, input logic [31:0] pc);
      return {alu, s1, s2, rkd, dest, gw, mw, rfm, pc, 2'b00};
   endfunction

   // chk bits: {alu_op, src1, src2, rkd_value, dest}; control bits and pc always compared
   function automatic logic [149:0] mk_mask(input logic [4:0] chk);
      return {{12{chk[4]}}, {32{chk[3]}}, {32{chk[2]}}, {32{chk[1]}}, {5{chk[0]}},
              3'b111, 32'hffff_ffff, 2'b11};
   endfunction

   localparam logic [149:0] FullMask = {150{1'b1}};

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] enc3(input logic [16:0] op, input logic [4:0] rk,
                                        input logic [4:0] rj, input logic [4:0] rd);
      return {op, rk, rj, rd};
   endfunction

   function automatic logic [31:0] enc12(input logic [9:0] op, input logic [11:0] i12,
                                         input logic [4:0] rj, input logic [4:0] rd);
      return {op, i12, rj, rd};
   endfunction

   function automatic logic [31:0] enc16(input logic [5:0] op, input logic [15:0] i16,
                                         input logic [4:0] rj, input logic [4:0] rd);
      return {op, i16, rj, rd};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] inst;
      logic        taken;
      logic [31:0] target;
      logic [11:0] alu;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] rkd;
      logic [4:0]  dest;
      logic        gw;
      logic        mw;
      logic        rfm;
      logic [4:0]  chk;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input string name, input logic [31:0] inst, input logic taken,
                          input logic [31:0] target, input logic [11:0] alu,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] rkd,
                          input logic [4:0] dest, input logic gw, input logic mw,
                          input logic rfm, input logic [4:0] chk);
      vec_t v;
      v.name = name; v.inst = inst; v.taken = taken; v.target = target; v.alu = alu;
      v.s1 = s1; v.s2 = s2; v.rkd = rkd; v.dest = dest; v.gw = gw; v.mw = mw; v.rfm = rfm;
      v.chk = chk;
      vq.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] P = 32'h1c00_0100;

   logic [31:0] link;

   initial begin
      resetn = 1'b0; valid_1 = 1'b0; stage_1_to_2 = '0; allow_3 = 1'b1;
      exe_we = 1'b0; exe_dest = '0; mem_we = 1'b0; mem_dest = '0;
      wb_hz_we = 1'b0; wb_hz_dest = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;

      // Register state: r2=0x10, r3=3, r4=-16, r5=0x10
      add_vec("add",   enc3(17'h00020, 5'd3, 5'd2, 5'd6), 1'b0, 32'h0, 12'h001,
              32'h10, 32'h3, 32'h3, 5'd6, 1'b1, 1'b0, 1'b0, 5'b11111);
      add_vec("sub",   enc3(17'h00022, 5'd2, 5'd4, 5'd7), 1'b0, 32'h0, 12'h002,
              32'hffff_fff0, 32'h10, 32'h10, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11111);
      add_vec("sltu",  enc3(17'h00025, 5'd4, 5'd3, 5'd8), 1'b0, 32'h0, 12'h008,
              32'h3, 32'hffff_fff0, 32'hffff_fff0, 5'd8, 1'b1, 1'b0, 1'b0, 5'b11111);
      add_vec("xor",   enc3(17'h0002b, 5'd5, 5'd2, 5'd9), 1'b0, 32'h0, 12'h080,
              32'h10, 32'h10, 32'h10, 5'd9, 1'b1, 1'b0, 1'b0, 5'b11111);
      add_vec("nor",   enc3(17'h00028, 5'd3, 5'd0, 5'd15), 1'b0, 32'h0, 12'h020,
              32'h0, 32'h3, 32'h3, 5'd15, 1'b1, 1'b0, 1'b0, 5'b11111);
      add_vec("srai",  enc3(17'h00091, 5'd4, 5'd4, 5'd10), 1'b0, 32'h0, 12'h400,
              32'hffff_fff0, 32'h4, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 5'b11101);
      add_vec("addi",  enc12(10'h00a, 12'hfff, 5'd4, 5'd11), 1'b0, 32'h0, 12'h001,
              32'hffff_fff0, 32'hffff_ffff, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 5'b11101);
      add_vec("ldw",   enc12(10'h0a2, 12'h008, 5'd2, 5'd12), 1'b0, 32'h0, 12'h001,
              32'h10, 32'h8, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 5'b11101);
      add_vec("stw",   enc12(10'h0a6, 12'hffc, 5'd2, 5'd3), 1'b0, 32'h0, 12'h001,
              32'h10, 32'hffff_fffc, 32'h3, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11110);
      add_vec("lu12i", {7'h0a, 20'h12345, 5'd13}, 1'b0, 32'h0, 12'h800,
              32'h0, 32'h1234_5000, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 5'b10101);
      add_vec("beq_t", enc16(6'h16, 16'h0004, 5'd2, 5'd5), 1'b1, 32'h1c00_0110, 12'h0,
              32'h0, 32'h0, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010);
      add_vec("bne_n", enc16(6'h17, 16'h0004, 5'd2, 5'd5), 1'b0, 32'h0, 12'h0,
              32'h0, 32'h0, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010);
      add_vec("bne_t", enc16(6'h17, 16'hfff8, 5'd2, 5'd3), 1'b1, 32'h1c00_00e0, 12'h0,
              32'h0, 32'h0, 32'h3, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00010);
      add_vec("jirl",  enc16(6'h13, 16'h0003, 5'd2, 5'd14), 1'b1, 32'h0000_001c, 12'h001,
              P, 32'h4, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 5'b11101);
      add_vec("b",     {6'h14, 16'hffff, 10'h3ff}, 1'b1, 32'h1c00_00fc, 12'h0,
              32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      add_vec("unk",   32'hffff_ffff, 1'b0, 32'h0, 12'h0,
              32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000);

      // Reset state
      #12;
      check1("rst_valid_2", valid_2, 1'b0);
      check1("rst_allow_2", allow_2, 1'b1);
      check1("rst_br_taken", br_taken, 1'b0);
      check32("rst_pc", stage_2_to_3[33:2], 32'h1bff_fffc);
      resetn = 1'b1;
      next_cycle();

      // Preload registers
      rf_we = 1'b1;
      rf_waddr = 5'd2; rf_wdata = 32'h10;        next_cycle();
      rf_waddr = 5'd3; rf_wdata = 32'h3;         next_cycle();
      rf_waddr = 5'd4; rf_wdata = 32'hffff_fff0; next_cycle();
      rf_waddr = 5'd5; rf_wdata = 32'h10;        next_cycle();
      rf_we = 1'b0;

      // Table-driven decode vectors
      for (int i = 0; i < vq.size(); i++) begin
         valid_1 = 1'b1;
         stage_1_to_2 = {vq[i].inst, P};
         next_cycle();
         valid_1 = 1'b0;
         #2;
         check1({vq[i].name, "_valid_2"}, valid_2, 1'b1);
         check1({vq[i].name, "_br_taken"}, br_taken, vq[i].taken);
         if (vq[i].taken) check32({vq[i].name, "_br_target"}, br_target, vq[i].target);
         check_bus({vq[i].name, "_bundle"}, stage_2_to_3,
                   mk_bundle(vq[i].alu, vq[i].s1, vq[i].s2, vq[i].rkd, vq[i].dest,
                             vq[i].gw, vq[i].mw, vq[i].rfm, P),
                   mk_mask(vq[i].chk));
         next_cycle();
      end

      // RAW hazard: addi r1,r0,5 then add.w r2,r1,r1 across exe/mem/wb
      valid_1 = 1'b1;
      stage_1_to_2 = {enc12(10'h00a, 12'h005, 5'd0, 5'd1), 32'h1c00_0200};
      wb_hz_we = 1'b1; wb_hz_dest = 5'd1;
      next_cycle();
      stage_1_to_2 = {enc3(17'h00020, 5'd1, 5'd1, 5'd2), 32'h1c00_0204};
      #2;
      check1("addi_valid_2", valid_2, 1'b1);
      check1("addi_allow_2", allow_2, 1'b1);
      check_bus("addi_bundle", stage_2_to_3,
                mk_bundle(12'h001, 32'h0, 32'h5, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h1c00_0200),
                mk_mask(5'b11101));
      next_cycle();
      valid_1 = 1'b0; wb_hz_we = 1'b0; exe_we = 1'b1; exe_dest = 5'd1;
      #2;
      check1("hz_exe_valid_2", valid_2, 1'b0);
      check1("hz_exe_allow_2", allow_2, 1'b0);
      next_cycle();
      exe_we = 1'b0; mem_we = 1'b1; mem_dest = 5'd1;
      #2;
      check1("hz_mem_valid_2", valid_2, 1'b0);
      next_cycle();
      mem_we = 1'b0; wb_hz_we = 1'b1; wb_hz_dest = 5'd1;
      rf_we = 1'b1; rf_waddr = 5'd1; rf_wdata = 32'h5;
      #2;
      check1("hz_wb_valid_2", valid_2, 1'b0);
      next_cycle();
      wb_hz_we = 1'b0; rf_we = 1'b0;
      #2;
      check1("hz_done_valid_2", valid_2, 1'b1);
      check_bus("hz_done_bundle", stage_2_to_3,
                mk_bundle(12'h001, 32'h5, 32'h5, 32'h5, 5'd2, 1'b1, 1'b0, 1'b0, 32'h1c00_0204),
                FullMask);
      next_cycle();

      // beq r0,r0,+8 drops the fall-through instruction
      valid_1 = 1'b1;
      stage_1_to_2 = {enc16(6'h16, 16'h0008, 5'd0, 5'd0), 32'h1c00_0000};
      next_cycle();
      stage_1_to_2 = {enc3(17'h00020, 5'd3, 5'd2, 5'd6), 32'h1c00_0004};
      #2;
      check1("beq_br_taken", br_taken, 1'b1);
      check32("beq_br_target", br_target, 32'h1c00_0020);
      check1("beq_allow_2", allow_2, 1'b1);
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("beq_drop_valid_2", valid_2, 1'b0);
      check1("beq_drop_br_taken", br_taken, 1'b0);
      next_cycle();

      // bl +0x100 at 0x1c000010
      valid_1 = 1'b1;
      stage_1_to_2 = {6'h15, 16'h0100, 10'h000, 32'h1c00_0010};
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("bl_br_taken", br_taken, 1'b1);
      check32("bl_br_target", br_target, 32'h1c00_0410);
      check32("bl_dest", {27'd0, stage_2_to_3[41:37]}, 32'd1);
      check1("bl_gr_we", stage_2_to_3[36], 1'b1);
      link = stage_2_to_3[137:106] + stage_2_to_3[105:74];
      check32("bl_link", link, 32'h1c00_0014);
      next_cycle();

      // Back-pressure from execute for three cycles
      valid_1 = 1'b1;
      stage_1_to_2 = {enc3(17'h00020, 5'd3, 5'd2, 5'd6), 32'h1c00_0300};
      next_cycle();
      allow_3 = 1'b0;
      stage_1_to_2 = {enc3(17'h0002b, 5'd5, 5'd2, 5'd9), 32'h1c00_0304};
      for (int k = 0; k < 3; k++) begin
         #2;
         check1("bp_valid_2", valid_2, 1'b1);
         check1("bp_allow_2", allow_2, 1'b0);
         check_bus("bp_bundle", stage_2_to_3,
                   mk_bundle(12'h001, 32'h10, 32'h3, 32'h3, 5'd6, 1'b1, 1'b0, 1'b0,
                             32'h1c00_0300), FullMask);
         next_cycle();
      end
      allow_3 = 1'b1;
      #2;
      check1("bp_release_allow_2", allow_2, 1'b1);
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("bp_next_valid_2", valid_2, 1'b1);
      check_bus("bp_next_bundle", stage_2_to_3,
                mk_bundle(12'h080, 32'h10, 32'h10, 32'h10, 5'd9, 1'b1, 1'b0, 1'b0,
                          32'h1c00_0304), FullMask);
      next_cycle();

      // r0 write is ignored; r0 source never hazards
      rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'hdead_beef;
      next_cycle();
      rf_we = 1'b0;
      valid_1 = 1'b1;
      stage_1_to_2 = {enc3(17'h0002a, 5'd0, 5'd0, 5'd17), 32'h1c00_0400};
      exe_we = 1'b1; exe_dest = 5'd0;
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("r0_valid_2", valid_2, 1'b1);
      check_bus("r0_bundle", stage_2_to_3,
                mk_bundle(12'h040, 32'h0, 32'h0, 32'h0, 5'd17, 1'b1, 1'b0, 1'b0, 32'h1c00_0400),
                FullMask);
      next_cycle();
      exe_we = 1'b0;

      // Asynchronous reset while a taken branch is held
      valid_1 = 1'b1;
      stage_1_to_2 = {enc16(6'h16, 16'h0008, 5'd0, 5'd0), 32'h1c00_0500};
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("mr_pre_br_taken", br_taken, 1'b1);
      resetn = 1'b0;
      #1;
      check1("mr_valid_2", valid_2, 1'b0);
      check1("mr_br_taken", br_taken, 1'b0);
      check1("mr_allow_2", allow_2, 1'b1);
      next_cycle();
      resetn = 1'b1;
      valid_1 = 1'b1;
      stage_1_to_2 = {enc3(17'h00020, 5'd3, 5'd2, 5'd6), 32'h1c00_0600};
      next_cycle();
      valid_1 = 1'b0;
      #2;
      check1("mr_after_valid_2", valid_2, 1'b1);
      check_bus("mr_after_bundle", stage_2_to_3,
                mk_bundle(12'h001, 32'h10, 32'h3, 32'h3, 5'd6, 1'b1, 1'b0, 1'b0, 32'h1c00_0600),
                FullMask);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stage_2_id.md
Name: stage_2_id

Overview:
- Second stage of the five-stage LA32 pipeline; sits directly downstream of the fetch stage.
- Latches {inst,pc} from fetch and decodes the exp7 instruction subset.
- Reads the 32x32 register file and stalls on RAW hazards; no forwarding.
- Resolves branches and returns br_taken/br_target to fetch, then hands a decoded bundle to execute under valid/allow handshake.

Parameters:
- RESET_PC, 32'h1bff_fffc, pc value loaded into the holding register at reset; debug visibility only.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- valid_1  in  1  fetch holds a valid instruction
- allow_2  out  1  this stage can accept fetch's instruction this cycle
- stage_1_to_2  in  64  {inst[63:32], pc[31:0]}
- br_taken  out  1  redirect fetch this cycle
- br_target  out  32  redirect address
- valid_2  out  1  decoded bundle on stage_2_to_3 is valid
- allow_3  in  1  execute can accept
- stage_2_to_3  out  150  {alu_op[149:138], src1[137:106], src2[105:74], rkd_value[73:42], dest[41:37], gr_we[36], mem_we[35], res_from_mem[34], pc[33:2], 2'b0}
- exe_we/exe_dest, mem_we/mem_dest, wb_hz_we/wb_hz_dest  in  1/5 each  valid-qualified destination of each downstream stage
- rf_we  in  1  register-file write enable from writeback
- rf_waddr  in  5  register-file write address
- rf_wdata  in  32  register-file write data

Behaviour:
- Holding registers: valid_r, inst_r, pc_r.
  - Reset (resetn=0, async) gives valid_r=0, inst_r=0, pc_r=RESET_PC.
  - Outputs while in reset: valid_2=0, br_taken=0, allow_2=1.
- ready_go = !stall.
- allow_2 = !valid_r | (ready_go & allow_3).
- valid_2 = valid_r & ready_go.
- When allow_2=1: valid_r <= valid_1 & !br_taken; inst_r/pc_r <= stage_1_to_2. Otherwise all hold.
- Branch cancel: fetch has already fetched pc+4 when a branch sits here. That instruction is dropped (valid_r <= 0) in the same cycle br_taken=1.
- Decode subset: add.w, sub.w, slt, sltu, nor, and, or, xor, slli.w, srli.w, srai.w, addi.w, ld.w, st.w, jirl, b, bl, beq, bne, lu12i.w.
  - Unknown opcode decodes as a NOP: gr_we=0, mem_we=0.
- Immediates:
  - si12 sign-extended.
  - ui5 zero-extended.
  - si20 placed as {si20,12'b0}.
  - offs16/offs26 sign-extended and shifted left by 2.
- Sources:
  - rj is read for all instructions except b, bl, lu12i.w.
  - rk is read for 3R ops.
  - rd is read as the second source for beq, bne, st.w.
  - Register r0 reads as 0 and never hazards.
- Destinations:
  - bl writes r1.
  - jirl writes rd with pc+4; bl's link value is also pc+4.
  - b, beq, bne, st.w: gr_we=0.
- stall = valid_r & (any read source != 0 that equals a dest with matching we among exe/mem/wb_hz).
- Register file (sub-module) reads combinationally and writes on posedge when rf_we & rf_waddr != 0.
  - A read of the address being written in the same cycle returns the old value; the wb_hz stall covers this.
- Branch resolution, with br_taken = valid_r & ready_go & taken:
  - taken = beq&(rj==rd) | bne&(rj!=rd) | jirl | b | bl.
  - beq/bne/b/bl target = pc_r + offs.
  - jirl target = rj_value + offs16<<2.
- A stalled branch never asserts br_taken.
- Simultaneous stall and allow_3=0: hold.
- allow_3=0 with no stall: hold; valid_2 stays asserted, bundle stable.

Decomposition:
- Shared package: opcode/funct constants, ALU_OP one-hot bit indices (12), and bus width localparams (BUS_1_2=64, BUS_2_3=150).
- One sub-module: regfile (2 read ports, 1 write port, 32x32).

Test Plan:
- Reset mid-run: resetn low while valid_r=1 → valid_2=0 and br_taken=0 immediately (async); after release, first valid_1 is latched.
- addi.w r1,r0,5 with wb writing r1: decoded src1=0, src2=5, dest=1, gr_we=1. A following add.w r2,r1,r1 stalls while exe/mem/wb_hz carry dest 1, then issues with rkd correct.
- beq r0,r0,+8 at pc 0x1c000000: br_taken=1, br_target=0x1c000020 for one cycle. The incoming fetch instruction (0x1c000004) is dropped (valid_2=0 next cycle).
- bl +0x100 at pc 0x1c000010: dest=1, link value 0x1c000014, br_target=0x1c000410.
- allow_3=0 for 3 cycles with a valid bundle: allow_2=0, stage_2_to_3 and valid_2 held constant; the fetch instruction is accepted the cycle allow_3 returns.
- Write to r0 via rf_we: a subsequent read of r0 returns 0, and an instruction sourcing r0 does not stall even when exe_dest=0 with exe_we=1.
